// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default geometry and FSM encodings.
package dmem_arbiter_pkg;

  // Defaults match the 128x16 data_memory.
  localparam int DMEM_ADDR_W   = 7;
  localparam int DMEM_DATA_W   = 16;
  localparam int DMEM_MAX_LOCK = 8;

  // Encodings kept identical to the legacy header values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_lock_timer.sv
// Lock timer: counts consecutive locked-ownership cycles while the other port waits.
module lock_timer
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = $clog2(MAX_LOCK);

  logic [CNT_W-1:0] cnt;

  // Counter: clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expire on the last permitted locked cycle.
  assign expire = (cnt == CNT_W'(MAX_LOCK - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the CPU (port 0)
// and the debug/loader (port 1) with owner-based round-robin, optional lock and lock timeout.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic              lock_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              lock_abort,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;      // last owner; a tie goes to the other port
  logic       lock_inc;
  logic       lock_expire;
  logic       abort_nxt;

  // Next owner: tie-break on last owner, locked hold bounded by the lock timer.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    lock_inc  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_0 && req_1) begin
          state_nxt = last ? ST_OWN0 : ST_OWN1;
        end else if (req_0) begin
          state_nxt = ST_OWN0;
        end else if (req_1) begin
          state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (req_0 && lock_0 && req_1) begin
          if (lock_expire) begin
            state_nxt = ST_OWN1;
            abort_nxt = 1'b1;
          end else begin
            lock_inc = 1'b1;
          end
        end else if (req_1) begin
          state_nxt = ST_OWN1;
        end else if (!req_0) begin
          state_nxt = ST_IDLE;
        end
        if (state_nxt != ST_OWN0) last_nxt = 1'b0;
      end
      ST_OWN1: begin
        if (req_1 && lock_1 && req_0) begin
          if (lock_expire) begin
            state_nxt = ST_OWN0;
            abort_nxt = 1'b1;
          end else begin
            lock_inc = 1'b1;
          end
        end else if (req_0) begin
          state_nxt = ST_OWN0;
        end else if (!req_1) begin
          state_nxt = ST_IDLE;
        end
        if (state_nxt != ST_OWN1) last_nxt = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Any cycle that is not a locked hold under contention restarts the count.
  lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_timer (
    .clk    (clk),
    .rst    (rst),
    .inc    (lock_inc),
    .clr    (!lock_inc),
    .expire (lock_expire)
  );

  // Arbiter state, last owner and the registered timeout pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      lock_abort <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      lock_abort <= abort_nxt;
    end
  end

  // Grants follow the registered owner, so they drop as soon as reset clears the state.
  assign gnt_0 = (state == ST_OWN0) && req_0;
  assign gnt_1 = (state == ST_OWN1) && req_1;

  // Memory port driven from the granted requester, idle otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_0) begin
      mem_we    = we_0;
      mem_re    = !we_0;
      mem_addr  = addr_0;
      mem_wdata = wdata_0;
    end else if (gnt_1) begin
      mem_we    = we_1;
      mem_re    = !we_1;
      mem_addr  = addr_1;
      mem_wdata = wdata_1;
    end
  end

  // Read return: capture data at the end of a read grant, valid for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rdata_0  <= '0;
      rdata_1  <= '0;
    end else begin
      rvalid_0 <= gnt_0 && !we_0;
      rvalid_1 <= gnt_1 && !we_1;
      if (gnt_0 && !we_0) rdata_0 <= mem_rdata;
      if (gnt_1 && !we_1) rdata_1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, a reset-during-write sequence,
// and randomized traffic against a port-indexed reference model.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int ML = 8;

  // {req, we, lock} per port
  localparam bit [2:0] NO = 3'b000;
  localparam bit [2:0] RD = 3'b100;
  localparam bit [2:0] WR = 3'b110;
  localparam bit [2:0] RL = 3'b101;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [1:0]    lock = '0;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1, lock_abort, mem_we, mem_re;
  logic [DW-1:0] rdata_0, rdata_1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          mem_wipe = 1'b1;
  logic [DW-1:0] mem [128];

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_LOCK (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_0      (req[0]),
    .we_0       (we[0]),
    .lock_0     (lock[0]),
    .addr_0     (addr[0]),
    .wdata_0    (wdata[0]),
    .req_1      (req[1]),
    .we_1       (we[1]),
    .lock_1     (lock[1]),
    .addr_1     (addr[1]),
    .wdata_1    (wdata[1]),
    .gnt_0      (gnt_0),
    .gnt_1      (gnt_1),
    .rvalid_0   (rvalid_0),
    .rvalid_1   (rvalid_1),
    .rdata_0    (rdata_0),
    .rdata_1    (rdata_1),
    .lock_abort (lock_abort),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: word i preloads to i*16+1, synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wipe) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'(i * 16 + 1);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit        rs;
    bit [2:0]  p0;
    bit [6:0]  a0;
    bit [15:0] d0;
    bit [2:0]  p1;
    bit [6:0]  a1;
    bit [15:0] d1;
    bit [4:0]  e;    // {gnt_0, gnt_1, rvalid_0, rvalid_1, lock_abort}
    bit [15:0] rd0;
    bit [15:0] rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rs, bit [2:0] p0, int a0, int d0, bit [2:0] p1, int a1, int d1,
                              bit [4:0] e, int rd0, int rd1);
    vec_t v;
    v.rs = rs;  v.p0 = p0; v.a0 = 7'(a0); v.d0 = 16'(d0);
    v.p1 = p1;  v.a1 = 7'(a1); v.d1 = 16'(d1);
    v.e  = e;   v.rd0 = 16'(rd0); v.rd1 = 16'(rd1);
    return v;
  endfunction

  // Reference model state
  int            own, lastp, held;
  bit [1:0]      mv, eg, pend, lmode;
  bit            mab;
  logic [DW-1:0] mrd [2];
  logic [DW-1:0] rmem [128];

  initial begin
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

    // Reset and single read
    tbl.push_back(mk(0, NO, 0, 0, NO, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(1, NO, 0, 0, RD, 3, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(1, NO, 0, 0, RD, 3, 0, 5'b01000, 0, 0));
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00010, 0, 'h31));
    // Tie after reset, then alternation
    tbl.push_back(mk(1, RD, 0, 0, RD, 1, 0, 5'b00000, 0, 'h31));
    tbl.push_back(mk(1, RD, 0, 0, RD, 1, 0, 5'b10000, 0, 'h31));
    tbl.push_back(mk(1, RD, 2, 0, RD, 1, 0, 5'b01100, 'h01, 'h31));
    tbl.push_back(mk(1, RD, 2, 0, RD, 4, 0, 5'b10010, 'h01, 'h11));
    tbl.push_back(mk(1, NO, 0, 0, RD, 4, 0, 5'b01100, 'h21, 'h11));
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00010, 'h21, 'h41));
    // Locked read-modify-write on address 10
    tbl.push_back(mk(1, RL, 10, 0, RD, 10, 0, 5'b00000, 'h21, 'h41));
    tbl.push_back(mk(1, RL, 10, 0, RD, 10, 0, 5'b10000, 'h21, 'h41));
    tbl.push_back(mk(1, WR, 10, 'hBEEF, RD, 10, 0, 5'b10100, 'hA1, 'h41));
    tbl.push_back(mk(1, NO, 0, 0, RD, 10, 0, 5'b01000, 'hA1, 'h41));
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00010, 'hA1, 'hBEEF));
    // Lock timeout: 8 grants to port 0, then abort with grant to port 1
    tbl.push_back(mk(1, RL, 20, 0, RD, 21, 0, 5'b00000, 'hA1, 'hBEEF));
    tbl.push_back(mk(1, RL, 20, 0, RD, 21, 0, 5'b10000, 'hA1, 'hBEEF));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1, RL, 20, 0, RD, 21, 0, 5'b10100, 'h141, 'hBEEF));
    tbl.push_back(mk(1, RL, 20, 0, RD, 21, 0, 5'b01101, 'h141, 'hBEEF));
    tbl.push_back(mk(1, RL, 20, 0, NO, 0, 0, 5'b10010, 'h141, 'h151));
    // Idle release, then write/read-back on port 1 with 1-cycle latency
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00100, 'h141, 'h151));
    tbl.push_back(mk(1, NO, 0, 0, WR, 30, 'h1234, 5'b00000, 'h141, 'h151));
    tbl.push_back(mk(1, NO, 0, 0, WR, 30, 'h1234, 5'b01000, 'h141, 'h151));
    tbl.push_back(mk(1, NO, 0, 0, RD, 30, 0, 5'b01000, 'h141, 'h151));
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00010, 'h141, 'h1234));
    // Owner drops request while the other waits: one bubble cycle
    tbl.push_back(mk(1, RD, 1, 0, NO, 0, 0, 5'b00000, 'h141, 'h1234));
    tbl.push_back(mk(1, RD, 1, 0, NO, 0, 0, 5'b10000, 'h141, 'h1234));
    tbl.push_back(mk(1, NO, 0, 0, RD, 2, 0, 5'b00100, 'h11, 'h1234));
    tbl.push_back(mk(1, NO, 0, 0, RD, 2, 0, 5'b01000, 'h11, 'h1234));
    tbl.push_back(mk(1, NO, 0, 0, NO, 0, 0, 5'b00010, 'h11, 'h21));

    repeat (2) @(negedge clk);
    mem_wipe = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      logic [AW-1:0] ea;
      v = tbl[i];
      @(negedge clk);
      rst = v.rs;
      req  = {v.p1[2], v.p0[2]};
      we   = {v.p1[1], v.p0[1]};
      lock = {v.p1[0], v.p0[0]};
      addr[0] = v.a0;  wdata[0] = v.d0;
      addr[1] = v.a1;  wdata[1] = v.d1;
      #1;
      ea = v.e[4] ? v.a0 : (v.e[3] ? v.a1 : '0);
      chk($sformatf("vec%0d gnt", i), {gnt_0, gnt_1}, v.e[4:3]);
      chk($sformatf("vec%0d rvalid", i), {rvalid_0, rvalid_1}, v.e[2:1]);
      chk($sformatf("vec%0d lock_abort", i), lock_abort, v.e[0]);
      chk($sformatf("vec%0d rdata", i), {rdata_0, rdata_1}, {v.rd0, v.rd1});
      chk($sformatf("vec%0d mem_we", i), mem_we, (v.e[4] & v.p0[1]) | (v.e[3] & v.p1[1]));
      chk($sformatf("vec%0d mem_re", i), mem_re, (v.e[4] & ~v.p0[1]) | (v.e[3] & ~v.p1[1]));
      chk($sformatf("vec%0d mem_addr", i), mem_addr, ea);
    end

    // Reset asserted in the middle of a granted write to address 5
    @(negedge clk);
    req = 2'b01; we = 2'b01; lock = 2'b00; addr[0] = 7'd5; wdata[0] = 16'hDEAD;
    @(negedge clk);
    #1;
    chk("rstw gnt_0", gnt_0, 1'b1);
    chk("rstw mem_we", mem_we, 1'b1);
    chk("rstw mem_addr", mem_addr, 7'd5);
    rst = 1'b0;
    #1;
    chk("rstw outputs", {gnt_0, gnt_1, mem_we, mem_re, rvalid_0, rvalid_1, lock_abort}, 7'b0);
    chk("rstw rdata", {rdata_0, rdata_1}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstw mem5", mem[5], 16'h0051);

    // Randomized traffic against the reference model
    req = '0;
    mem_wipe = 1'b1;
    repeat (2) @(negedge clk);
    mem_wipe = 1'b0;
    rst = 1'b1;
    own = -1; lastp = 1; held = 0; mv = '0; mab = 1'b0;
    mrd[0] = '0; mrd[1] = '0; pend = '0; lmode = '0;
    for (int i = 0; i < 128; i++) rmem[i] = 16'(i * 16 + 1);

    for (int c = 0; c < 4000; c++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 49) == 0) lmode[p] = ~lmode[p];
        if (!pend[p] && ($urandom_range(0, 99) < (lmode[p] ? 90 : 55))) begin
          pend[p]  = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          lock[p]  = lmode[p] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
          addr[p]  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
          wdata[p] = 16'($urandom);
        end
        req[p] = pend[p];
      end
      #1;
      for (int p = 0; p < 2; p++) eg[p] = (own == p) && req[p];
      ea = eg[0] ? addr[0] : (eg[1] ? addr[1] : '0);
      ed = eg[0] ? wdata[0] : (eg[1] ? wdata[1] : '0);
      chk("rnd gnt", {gnt_1, gnt_0}, eg);
      chk("rnd mem_we", mem_we, (eg[0] & we[0]) | (eg[1] & we[1]));
      chk("rnd mem_re", mem_re, (eg[0] & ~we[0]) | (eg[1] & ~we[1]));
      chk("rnd mem_addr", mem_addr, ea);
      chk("rnd mem_wdata", mem_wdata, ed);
      chk("rnd rvalid", {rvalid_1, rvalid_0}, mv);
      chk("rnd rdata", {rdata_1, rdata_0}, {mrd[1], mrd[0]});
      chk("rnd lock_abort", lock_abort, mab);

      // Advance the model across the coming clock edge
      mv = '0;
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          pend[p] = 1'b0;
          if (we[p]) begin
            rmem[addr[p]] = wdata[p];
          end else begin
            mv[p]  = 1'b1;
            mrd[p] = rmem[addr[p]];
          end
        end
      end
      mab = 1'b0;
      if (own < 0) begin
        if (req[0] && req[1]) own = 1 - lastp;
        else if (req[0]) own = 0;
        else if (req[1]) own = 1;
        held = 0;
      end else begin
        int o;
        o = 1 - own;
        if (req[own] && lock[own] && req[o]) begin
          if (held == ML - 1) begin
            mab = 1'b1; lastp = own; own = o; held = 0;
          end else begin
            held++;
          end
        end else if (req[o]) begin
          lastp = own; own = o; held = 0;
        end else if (req[own]) begin
          held = 0;
        end else begin
          lastp = own; own = -1; held = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
